// File: rtl/apb_wait_responder.sv
// APB completer with a word register file and a fixed number of
// wait states inserted before every completion.
module apb_wait_responder #(
  parameter int DEPTH = 16,
  parameter int WAIT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          err;
  logic          done;
  logic          we;
  logic          unused_prot;

  assign unused_prot = ^in_pprot;

  assign idx = in_paddr[AW+1:2];
  assign err = (in_paddr[1:0] != 2'b00)
             | (in_paddr[31:AW+2] != '0);

  // Reset gates completion so an in-flight transfer never responds.
  assign done = (state_q == ACCESS) & in_psel
              & in_penable & (cnt_q == 8'd0)
              & reset;
  assign we   = done & in_pwrite & ~err;

  // Completion-cycle response; everything is zero otherwise.
  always_comb begin
    in_pready  = done;
    in_pslverr = done & err;
    in_prdata  = 32'd0;
    if (done & ~in_pwrite & ~err) begin
      in_prdata = mem_q[idx];
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_psel & ~in_penable) begin
          state_d = ACCESS;
          cnt_d   = 8'(WAIT);
        end
      end
      ACCESS: begin
        if (!in_psel) begin
          state_d = IDLE;
        end else if (!in_penable) begin
          cnt_d = 8'(WAIT);
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register file with byte-lane writes at completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= 32'd0;
      end
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (in_pstrb[i]) begin
          mem_q[idx][8*i +: 8] <= in_pwdata[8*i +: 8];
        end
      end
    end
  end

endmodule
